// File: rtl/decoder_proj_pkg.sv
// decoder_proj_pkg: shared scan-controller state encoding and decoder input width.
package decoder_proj_pkg;

    localparam int DEC_CODE_W = 7;

    typedef enum logic [1:0] {
        ST_ARB,
        ST_DWELL,
        ST_BLANK
    } state_t;

endpackage

// File: rtl/decoder_scan_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int PW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic             found
);

    logic [PW-1:0] j;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = PW'((int'(ptr) + k) % N_REQ);
            if (!found && req[j]) begin
                gnt[j] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: round-robin time-sharing of the decoder input among requesters,
// each code held for a fixed dwell window followed by an optional blanking gap.
module decoder_scan_ctrl
    import decoder_proj_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int CODE_W = DEC_CODE_W,
    parameter int DWELL  = 8,
    parameter int BLANK  = 1
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    en,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*CODE_W-1:0] code,
    output logic [CODE_W-1:0]       dec_in,
    output logic [N_REQ-1:0]        dec_sel,
    output logic                    dec_valid,
    output logic [N_REQ-1:0]        ack,
    output logic                    busy
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2((DWELL > BLANK ? DWELL : BLANK) + 1);

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [PW-1:0]      ptr, ptr_n, gidx;
    logic [N_REQ-1:0]   gnt, sel_n, ack_n;
    logic               found, valid_n;
    logic [CODE_W-1:0]  gcode, din_n;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .gnt   (gnt),
        .found (found)
    );

    always_comb begin
        gidx  = '0;
        gcode = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                gidx  = PW'(i);
                gcode = code[i*CODE_W +: CODE_W];
            end
        end
    end

    // Outputs are computed one cycle ahead so dec_in/dec_sel/ack leave straight from flops.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        sel_n   = dec_sel;
        din_n   = dec_in;
        case (state)
            ST_ARB: begin
                if (en && found) begin
                    state_n = ST_DWELL;
                    cnt_n   = CW'(DWELL - 1);
                    ptr_n   = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
                    sel_n   = gnt;
                    din_n   = gcode;
                end
            end
            ST_DWELL: begin
                if (cnt == '0) begin
                    state_n = (BLANK > 0) ? ST_BLANK : ST_ARB;
                    cnt_n   = CW'((BLANK > 0) ? BLANK - 1 : 0);
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_BLANK: begin
                if (cnt == '0) state_n = ST_ARB;
                else cnt_n = cnt - 1'b1;
            end
            default: state_n = ST_ARB;
        endcase
        valid_n = (state_n == ST_DWELL);
        sel_n   = valid_n ? sel_n : '0;
        din_n   = valid_n ? din_n : '0;
        ack_n   = (valid_n && cnt_n == '0) ? sel_n : '0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= ST_ARB;
            cnt       <= '0;
            ptr       <= '0;
            dec_in    <= '0;
            dec_sel   <= '0;
            dec_valid <= 1'b0;
            ack       <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ptr       <= ptr_n;
            dec_in    <= din_n;
            dec_sel   <= sel_n;
            dec_valid <= valid_n;
            ack       <= ack_n;
        end
    end

    assign busy = (state != ST_ARB);

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb_decoder_scan_ctrl: directed scenarios plus random traffic against a slot-timeline model.
module tb_decoder_scan_ctrl;

    localparam int N  = 4;
    localparam int W  = 7;
    localparam int DW = 8;
    localparam int BL = 1;

    logic             clk = 1'b0;
    logic             rst, en;
    logic [N-1:0]     req;
    logic [N*W-1:0]   code;
    logic [W-1:0]     dec_in;
    logic [N-1:0]     dec_sel, ack;
    logic             dec_valid, busy;

    decoder_scan_ctrl #(.N_REQ(N), .CODE_W(W), .DWELL(DW), .BLANK(BL)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .en        (en),
        .req       (req),
        .code      (code),
        .dec_in    (dec_in),
        .dec_sel   (dec_sel),
        .dec_valid (dec_valid),
        .ack       (ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a slot is the grant edge g plus a timeline of DW valid cycles and BL blank cycles.
    int       e = 0;
    int       g = 0;
    int       owner = 0;
    int       mptr = 0;
    bit       active = 1'b0;
    logic [W-1:0] lcode = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, e, obs, exp);
        end
    endtask

    task automatic tick();
        int  d;
        bit  v, fnd;
        @(posedge clk);
        e++;
        if (rst) begin
            active = 1'b0;
            mptr   = 0;
        end else if (!active || e > g + DW + BL) begin
            active = 1'b0;
            if (en && req != '0) begin
                fnd = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!fnd && req[(mptr + k) % N]) begin
                        owner = (mptr + k) % N;
                        fnd   = 1'b1;
                    end
                end
                lcode  = code[owner*W +: W];
                mptr   = (owner + 1) % N;
                g      = e;
                active = 1'b1;
            end
        end
        #1;
        d = e - g;
        v = active && d < DW;
        chk("dec_valid", 32'(dec_valid), 32'(v));
        chk("dec_in", 32'(dec_in), v ? 32'(lcode) : 32'd0);
        chk("dec_sel", 32'(dec_sel), v ? (32'd1 << owner) : 32'd0);
        chk("ack", 32'(ack), (v && d == DW - 1) ? (32'd1 << owner) : 32'd0);
        chk("busy", 32'(busy), 32'(active && d < DW + BL));
        chk("ptr", 32'(dut.ptr), 32'(mptr));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run(2);
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        req  = '0;
        code = '0;
        do_reset();
        en   = 1'b1;
        req  = 4'b0001;
        code = {7'h00, 7'h00, 7'h00, 7'b1101010};
        run(22);
        req  = 4'b1111;
        code = {7'h44, 7'h33, 7'h22, 7'h11};
        run(52);
        do_reset();
        req  = 4'b0011;
        run(45);
        do_reset();
        req  = 4'b0001;
        run(4);
        code[W-1:0] = 7'h15;
        req         = 4'b0000;
        run(12);
        do_reset();
        req = 4'b1111;
        run(3);
        en  = 1'b0;
        run(20);
        en  = 1'b1;
        do_reset();
        run(4);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        req = 4'b0100;
        run(14);
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(299) == 0);
            en  = ($urandom_range(9) != 0);
            req = N'($urandom);
            if ($urandom_range(3) == 0) code = (N*W)'($urandom);
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
